// File: rtl/puf_pkg.sv
// ============================================================================
// Module      : puf_pkg
// Description : Shared definitions for the PUF response sampler: FSM state
//               enumeration, default parameter constants and a counter-width
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package puf_pkg;

    // Sampler control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } puf_state_t;

    // Default configuration.
    localparam int unsigned C_RESP_W_DEF      = 4;
    localparam int unsigned C_SETTLE_CYC_DEF  = 1000;
    localparam int unsigned C_SAMPLE_DIV_DEF  = 50000;
    localparam int unsigned C_NUM_SAMPLES_DEF = 15;

    // Width of a counter that must hold every value 0..max_val.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/puf_bit_voter.sv
// ============================================================================
// Module      : puf_bit_voter
// Description : One arbiter bit's ones-counter with majority and
//               non-unanimity decode.
// Ports       : CLK, RST      - clock, asynchronous active-high reset
//               i_clr         - clear the ones-counter (new vote)
//               i_take        - sample strobe
//               i_bit         - synchronized arbiter bit
//               o_majority    - ones > NUM_SAMPLES/2
//               o_unstable    - vote not unanimous (0 unless
//                               PUF_SAMPLER_UNSTABLE_EN is defined)
// Config      : PUF_SAMPLER_UNSTABLE_EN enables the unanimity decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module puf_bit_voter
    import puf_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = C_NUM_SAMPLES_DEF
)(
    input  logic CLK,
    input  logic RST,
    input  logic i_clr,
    input  logic i_take,
    input  logic i_bit,
    output logic o_majority,
    output logic o_unstable
);

    localparam int unsigned C_CNT_W = cnt_w(NUM_SAMPLES);

    logic [C_CNT_W-1:0] r_ones;

    // The controller issues at most NUM_SAMPLES strobes per vote, so the
    // counter never exceeds NUM_SAMPLES and cannot wrap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ones <= '0;
        end else if (i_clr) begin
            r_ones <= '0;
        end else if (i_take && i_bit) begin
            r_ones <= r_ones + C_CNT_W'(1);
        end
    end

    assign o_majority = (32'(r_ones) > (NUM_SAMPLES / 2));

`ifdef PUF_SAMPLER_UNSTABLE_EN
    assign o_unstable = (r_ones != '0) && (32'(r_ones) != NUM_SAMPLES);
`else
    assign o_unstable = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/puf_response_sampler.sv
// ============================================================================
// Module      : puf_response_sampler
// Description : Samples RESP_W asynchronous arbiter outputs NUM_SAMPLES times
//               after a settle delay and presents a majority-voted response
//               with a valid/ready handshake.
// Ports       : CLK, RST      - clock, asynchronous active-high reset
//               resp_raw      - raw asynchronous arbiter outputs
//               start         - single-cycle vote request (honoured in IDLE)
//               busy          - vote in progress (SETTLE/SAMPLE)
//               resp_valid    - voted response available (DONE)
//               resp_ready    - consumer accepts the response
//               resp_out      - majority-voted response
//               unstable      - per-bit non-unanimous flag
// Config      : PUF_SAMPLER_UNSTABLE_EN enables the unstable flags; when
//               undefined they are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module puf_response_sampler
    import puf_pkg::*;
#(
    parameter int unsigned RESP_W      = C_RESP_W_DEF,
    parameter int unsigned SETTLE_CYC  = C_SETTLE_CYC_DEF,
    parameter int unsigned SAMPLE_DIV  = C_SAMPLE_DIV_DEF,
    parameter int unsigned NUM_SAMPLES = C_NUM_SAMPLES_DEF
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic [RESP_W-1:0] resp_raw,
    input  logic              start,
    output logic              busy,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [RESP_W-1:0] resp_out,
    output logic [RESP_W-1:0] unstable
);

    localparam int unsigned C_SET_W = cnt_w(SETTLE_CYC);
    localparam int unsigned C_DIV_W = cnt_w(SAMPLE_DIV);
    localparam int unsigned C_SMP_W = cnt_w(NUM_SAMPLES);

    puf_state_t         r_state;
    puf_state_t         w_state_nxt;

    logic [RESP_W-1:0]  r_sync1;
    logic [RESP_W-1:0]  r_sync2;

    logic [C_SET_W-1:0] r_settle_cnt;
    logic [C_DIV_W-1:0] r_div_cnt;
    logic [C_SMP_W-1:0] r_sample_cnt;

    logic               w_clr;
    logic               w_take;
    logic               w_load;
    logic               w_settle_last;
    logic               w_div_last;
    logic               w_all_taken;

    logic [RESP_W-1:0]  w_majority;
    logic [RESP_W-1:0]  w_unstable;
    logic [RESP_W-1:0]  r_resp_out;
    logic [RESP_W-1:0]  r_unstable;

    // Two-flop synchronizer for the asynchronous arbiter outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= resp_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_settle_last = ((32'(r_settle_cnt) + 1) >= SETTLE_CYC);
    assign w_div_last    = (32'(r_div_cnt) == (SAMPLE_DIV - 1));
    assign w_all_taken   = (32'(r_sample_cnt) == NUM_SAMPLES);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode. The cycle after the last sample is
    // spent with the counters final; the vote is registered on the way into
    // DONE so resp_out/unstable are glitch-free flops.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_take      = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SETTLE;
                    w_clr       = 1'b1;
                end
            end
            SETTLE: begin
                if (w_settle_last) begin
                    w_state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (w_all_taken) begin
                    w_state_nxt = DONE;
                    w_load      = 1'b1;
                end else if (r_div_cnt == '0) begin
                    w_take = 1'b1;
                end
            end
            DONE: begin
                // start is deliberately not examined here, even when the
                // handshake completes in this cycle.
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Settle, divider and sample counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_settle_cnt <= '0;
            r_div_cnt    <= '0;
            r_sample_cnt <= '0;
        end else if (w_clr) begin
            r_settle_cnt <= '0;
            r_div_cnt    <= '0;
            r_sample_cnt <= '0;
        end else begin
            if (r_state == SETTLE) begin
                r_settle_cnt <= r_settle_cnt + C_SET_W'(1);
            end
            if ((r_state == SAMPLE) && !w_all_taken) begin
                r_div_cnt <= w_div_last ? '0 : (r_div_cnt + C_DIV_W'(1));
            end
            if (w_take) begin
                r_sample_cnt <= r_sample_cnt + C_SMP_W'(1);
            end
        end
    end

    generate
        for (genvar i = 0; i < RESP_W; i++) begin : g_voter
            puf_bit_voter #(
                .NUM_SAMPLES (NUM_SAMPLES)
            ) u_voter (
                .CLK        (CLK),
                .RST        (RST),
                .i_clr      (w_clr),
                .i_take     (w_take),
                .i_bit      (r_sync2[i]),
                .o_majority (w_majority[i]),
                .o_unstable (w_unstable[i])
            );
        end
    endgenerate

    // Result registers keep the last vote outside DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_resp_out <= '0;
            r_unstable <= '0;
        end else if (w_load) begin
            r_resp_out <= w_majority;
            r_unstable <= w_unstable;
        end
    end

    assign resp_out   = r_resp_out;
    assign unstable   = r_unstable;
    assign resp_valid = (r_state == DONE);
    assign busy       = (r_state == SETTLE) || (r_state == SAMPLE);

endmodule

`default_nettype wire

// File: tb/tb_puf_response_sampler.sv
// ============================================================================
// Module      : tb_puf_response_sampler
// Description : Self-checking bench for puf_response_sampler with
//               RESP_W=4, SETTLE_CYC=8, SAMPLE_DIV=4, NUM_SAMPLES=5.
//               Expected votes come from per-bit ones counts of the values
//               applied to each sample slot.
// Config      : honours PUF_SAMPLER_UNSTABLE_EN for the unstable expectation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_puf_response_sampler;

    localparam int W   = 4;
    localparam int SET = 8;
    localparam int DIV = 4;
    localparam int N   = 5;
    // start -> resp_valid latency in cycles
    localparam int LAT = SET + 2 + (N - 1) * DIV + 1;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] resp_raw = '0;
    logic         start = 1'b0;
    logic         resp_ready = 1'b0;
    logic         busy;
    logic         resp_valid;
    logic [W-1:0] resp_out;
    logic [W-1:0] unstable;

    int           n_checks = 0;
    int           n_fail   = 0;

    logic [W-1:0] smp_vals [N];
    logic [W-1:0] last_out  = '0;
    logic [W-1:0] last_unst = '0;

    always #5 CLK = ~CLK;

    puf_response_sampler #(
        .RESP_W      (W),
        .SETTLE_CYC  (SET),
        .SAMPLE_DIV  (DIV),
        .NUM_SAMPLES (N)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .resp_raw   (resp_raw),
        .start      (start),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_out   (resp_out),
        .unstable   (unstable)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Reference vote: count ones per bit across the sample slots.
    task automatic model_vote(output logic [W-1:0] eo, output logic [W-1:0] eu);
        int ones;
        eo = '0;
        eu = '0;
        for (int i = 0; i < W; i++) begin
            ones = 0;
            for (int k = 0; k < N; k++) ones += int'(smp_vals[k][i]);
            eo[i] = (2 * ones > N);
`ifdef PUF_SAMPLER_UNSTABLE_EN
            eu[i] = (ones != 0) && (ones != N);
`endif
        end
    endtask

    // One complete vote. Slot k is sampled in cycle SET+1+k*DIV after the
    // start cycle; the next slot value is applied the cycle after.
    task automatic run_vote(input string tag, input int hold, input bit poke,
                            input bit ready_start);
        int           rise;
        bit           busy_ok;
        bit           keep_ok;
        bit           hold_ok;
        logic [W-1:0] eo;
        logic [W-1:0] eu;
        rise    = -1;
        busy_ok = 1'b1;
        keep_ok = 1'b1;
        hold_ok = 1'b1;
        model_vote(eo, eu);
        resp_raw = smp_vals[0];
        tick; tick; tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c <= LAT + 10 && rise < 0; c++) begin
            if (resp_valid) begin
                rise = c;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (resp_out !== last_out || unstable !== last_unst) keep_ok = 1'b0;
                for (int k = 0; k < N - 1; k++)
                    if (c == SET + 2 + k * DIV) resp_raw = smp_vals[k + 1];
                start = poke && (c == SET / 2 || c == SET + 2 + DIV);
                tick;
            end
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, rise, LAT);
        check_eq({tag, "_busy_during"}, busy_ok, 1);
        check_eq({tag, "_prev_held"}, keep_ok, 1);
        check_eq({tag, "_resp_out"}, resp_out, eo);
        check_eq({tag, "_unstable"}, unstable, eu);
        for (int h = 0; h < hold; h++) begin
            resp_raw = W'($urandom);
            tick;
            if (!resp_valid || busy || resp_out !== eo || unstable !== eu)
                hold_ok = 1'b0;
        end
        check_eq({tag, "_hold"}, hold_ok, 1);
        resp_ready = 1'b1;
        start      = ready_start;
        tick;
        resp_ready = 1'b0;
        start      = 1'b0;
        check_eq({tag, "_idle_valid"}, resp_valid, 0);
        check_eq({tag, "_idle_busy"}, busy, 0);
        tick;
        check_eq({tag, "_no_restart"}, busy, 0);
        check_eq({tag, "_out_kept"}, {resp_out, unstable}, {eo, eu});
        last_out  = eo;
        last_unst = eu;
    endtask

    initial begin
        bit idle_ok;

        // Reset state
        tick; tick;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", resp_valid, 0);
        check_eq("rst_out", resp_out, 0);
        check_eq("rst_unstable", unstable, 0);
        RST = 1'b0;

        // No self-triggered response
        idle_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            resp_raw = W'($urandom);
            tick;
            if (resp_valid || busy) idle_ok = 1'b0;
        end
        check_eq("idle_quiet", idle_ok, 1);

        // Constant 1010
        for (int k = 0; k < N; k++) smp_vals[k] = 4'b1010;
        run_vote("const1010", 0, 1'b0, 1'b0);

        // Bit 0 flips: 1,0,1,0,1
        for (int k = 0; k < N; k++) smp_vals[k] = (k % 2 == 0) ? 4'b1011 : 4'b1010;
        run_vote("bit0flip", 2, 1'b0, 1'b1);

        // Held response plus start pokes during SETTLE and SAMPLE
        for (int k = 0; k < N; k++) smp_vals[k] = 4'b0110;
        run_vote("hold_poke", 20, 1'b1, 1'b1);

        // Reset during the third sample
        for (int k = 0; k < N; k++) smp_vals[k] = 4'b1111;
        resp_raw = smp_vals[0];
        tick; tick; tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c < SET + 1 + 2 * DIV; c++) tick;
        RST = 1'b1;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_valid", resp_valid, 0);
        check_eq("midrst_out", resp_out, 0);
        check_eq("midrst_unstable", unstable, 0);
        tick;
        RST       = 1'b0;
        last_out  = '0;
        last_unst = '0;
        for (int k = 0; k < N; k++) smp_vals[k] = (k < 2) ? 4'b0101 : 4'b1100;
        run_vote("after_rst", 1, 1'b0, 1'b0);

        // Randomized votes
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++) smp_vals[k] = W'($urandom);
            run_vote($sformatf("rand%0d", r), int'($urandom_range(0, 5)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
